// File: rtl/ternary_pkg.sv
// Shared trit encodings, trit type and sequencer state enum for the
// balanced-ternary counter controller.
package ternary_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t T_NEG  = 2'b01;
    localparam trit_t T_ZERO = 2'b11;
    localparam trit_t T_POS  = 2'b10;
    localparam trit_t T_ILL  = 2'b00;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_TURN,
        S_DONE
    } state_t;

    // Orders legal trits as -1 -> 0, 0 -> 1, +1 -> 2 so a plain unsigned compare works.
    function automatic logic [1:0] trit_rank(input trit_t t);
        return {~t[0], t[0] & t[1]};
    endfunction

endpackage

// File: rtl/bt_compare.sv
// Balanced-ternary magnitude compare, MSB-first; also flags any 00 trit
// in either operand.
module bt_compare
    import ternary_pkg::*;
#(
    parameter int TRITS = 4
) (
    input  logic [2*TRITS-1:0] a_i,
    input  logic [2*TRITS-1:0] b_i,
    output logic               lt_o,
    output logic               eq_o,
    output logic               gt_o,
    output logic               illegal_o
);

    logic [TRITS-1:0] ill_t;
    logic [TRITS-1:0] diff_t;
    logic [TRITS-1:0] less_t;
    logic             decided;

    genvar gi;
    generate
        for (gi = 0; gi < TRITS; gi++) begin : g_trit
            trit_t ta;
            trit_t tb;
            assign ta          = a_i[2*gi +: 2];
            assign tb          = b_i[2*gi +: 2];
            assign ill_t[gi]   = (ta == T_ILL) || (tb == T_ILL);
            assign diff_t[gi]  = (ta != tb);
            assign less_t[gi]  = (trit_rank(ta) < trit_rank(tb));
        end
    endgenerate

    always_comb begin
        lt_o    = 1'b0;
        gt_o    = 1'b0;
        decided = 1'b0;
        for (int i = TRITS - 1; i >= 0; i--) begin
            if (!decided && diff_t[i]) begin
                decided = 1'b1;
                lt_o    = less_t[i];
                gt_o    = ~less_t[i];
            end
        end
    end

    assign eq_o      = ~(|diff_t);
    assign illegal_o = |ill_t;

endmodule

// File: rtl/ternary_count_sequencer.sv
// Drives load/direction of a balanced-ternary counter from start to target,
// either one-shot or bouncing between the two endpoints.
module ternary_count_sequencer
    import ternary_pkg::*;
#(
    parameter int TRITS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               mode_i,
    input  logic [2*TRITS-1:0] start_val_i,
    input  logic [2*TRITS-1:0] end_val_i,
    input  logic [2*TRITS-1:0] cnt_val_i,
    output logic               cnt_load_o,
    output logic [2*TRITS-1:0] cnt_data_o,
    output logic [1:0]         cnt_dir_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int W = 2 * TRITS;
    localparam logic [W-1:0] ALL_ZERO_TRITS = {TRITS{T_ZERO}};

    state_t       state_q, state_d;
    logic [W-1:0] start_q, start_d;
    logic [W-1:0] end_q, end_d;
    logic [W-1:0] target_q, target_d;
    logic         mode_q, mode_d;
    logic         err_q, err_d;

    logic [W-1:0] cmp_a, cmp_b;
    logic         cmp_lt, cmp_eq, cmp_gt, cmp_ill;

    // In IDLE the comparator vets the incoming start/end pair; otherwise it tracks the counter.
    assign cmp_a = (state_q == S_IDLE) ? start_val_i : cnt_val_i;
    assign cmp_b = (state_q == S_IDLE) ? end_val_i   : target_q;

    bt_compare #(.TRITS(TRITS)) u_cmp (
        .a_i       (cmp_a),
        .b_i       (cmp_b),
        .lt_o      (cmp_lt),
        .eq_o      (cmp_eq),
        .gt_o      (cmp_gt),
        .illegal_o (cmp_ill)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            start_q  <= '0;
            end_q    <= '0;
            target_q <= '0;
            mode_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            end_q    <= end_d;
            target_q <= target_d;
            mode_q   <= mode_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_d    = start_q;
        end_d      = end_q;
        target_d   = target_q;
        mode_d     = mode_q;
        err_d      = 1'b0;
        cnt_load_o = 1'b0;
        cnt_data_o = ALL_ZERO_TRITS;
        cnt_dir_o  = T_ZERO;
        busy_o     = 1'b0;
        done_o     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (cmp_ill) begin
                        err_d = 1'b1;
                    end else begin
                        start_d  = start_val_i;
                        end_d    = end_val_i;
                        target_d = end_val_i;
                        mode_d   = mode_i;
                        state_d  = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                busy_o = 1'b1;
                if (stop_i) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_load_o = 1'b1;
                    cnt_data_o = start_q;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                busy_o = 1'b1;
                if (stop_i) begin
                    state_d = S_IDLE;
                end else if (cmp_ill) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (cmp_lt) begin
                    cnt_dir_o = T_POS;
                end else if (cmp_gt) begin
                    cnt_dir_o = T_NEG;
                end else if (cmp_eq) begin
                    // Degenerate bounce (start == end) has nothing to reverse to.
                    state_d = (mode_q && (start_q != end_q)) ? S_TURN : S_DONE;
                end
            end
            S_TURN: begin
                busy_o = 1'b1;
                if (stop_i) begin
                    state_d = S_IDLE;
                end else begin
                    target_d = (target_q == end_q) ? start_q : end_q;
                    state_d  = S_RUN;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_ternary_count_sequencer.sv
// Directed bench: a behavioural counter closes the loop around the sequencer,
// table vectors cover one-shot runs, plus hand sequences for the corner cases.
module tb_ternary_count_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] start_val = 8'hFF;
    logic [7:0] end_val = 8'hFF;
    logic [7:0] cnt_val;
    logic       cnt_load;
    logic [7:0] cnt_data;
    logic [1:0] cnt_dir;
    logic       busy, done, err;

    int  cnt_int = 0;
    logic force_ill = 1'b0;
    int  n_vec = 0;
    int  n_miss = 0;

    always #5 clk = ~clk;

    ternary_count_sequencer #(.TRITS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .stop_i      (stop),
        .mode_i      (mode),
        .start_val_i (start_val),
        .end_val_i   (end_val),
        .cnt_val_i   (cnt_val),
        .cnt_load_o  (cnt_load),
        .cnt_data_o  (cnt_data),
        .cnt_dir_o   (cnt_dir),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    function automatic logic [7:0] enc(input int v);
        logic [7:0] r;
        int x;
        int m;
        r = 8'hFF;
        x = v;
        for (int i = 0; i < 4; i++) begin
            m = ((x % 3) + 3) % 3;
            if (m == 0) begin
                r[2*i +: 2] = 2'b11; x = x / 3;
            end else if (m == 1) begin
                r[2*i +: 2] = 2'b10; x = (x - 1) / 3;
            end else begin
                r[2*i +: 2] = 2'b01; x = (x + 1) / 3;
            end
        end
        return r;
    endfunction

    function automatic int dec(input logic [7:0] c);
        int s;
        s = 0;
        for (int i = 3; i >= 0; i--) begin
            s = s * 3 + ((c[2*i +: 2] == 2'b10) ? 1 : (c[2*i +: 2] == 2'b01) ? -1 : 0);
        end
        return s;
    endfunction

    // Counter stand-in: loads on strobe, steps by the direction trit.
    always @(posedge clk) begin
        if (cnt_load)               cnt_int <= dec(cnt_data);
        else if (cnt_dir == 2'b10)  cnt_int <= cnt_int + 1;
        else if (cnt_dir == 2'b01)  cnt_int <= cnt_int - 1;
    end

    assign cnt_val = force_ill ? (enc(cnt_int) & 8'hFC) : enc(cnt_int);

    task automatic chk(input string nm, input int act, input int exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp_v);
        end
    endtask

    task automatic kick(input logic [7:0] sv, input logic [7:0] ev, input logic md);
        @(negedge clk);
        start = 1'b1; start_val = sv; end_val = ev; mode = md;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    typedef struct {
        logic [7:0] sv;
        logic [7:0] ev;
        logic       md;
        logic       exp_err;
        int         start_v;
        int         steps;
        logic [1:0] dir;
        int         final_v;
    } vec_t;

    vec_t vecs[8];

    task automatic apply_vec(input int i);
        vec_t v;
        v = vecs[i];
        kick(v.sv, v.ev, v.md);
        if (v.exp_err) begin
            chk($sformatf("v%0d_err", i), err, 1);
            chk($sformatf("v%0d_busy", i), busy, 0);
            chk($sformatf("v%0d_load", i), cnt_load, 0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_err_clr", i), err, 0);
            chk($sformatf("v%0d_busy2", i), busy, 0);
            chk($sformatf("v%0d_load2", i), cnt_load, 0);
        end else begin
            chk($sformatf("v%0d_load", i), cnt_load, 1);
            chk($sformatf("v%0d_data", i), cnt_data, v.sv);
            chk($sformatf("v%0d_busy", i), busy, 1);
            chk($sformatf("v%0d_ldir", i), cnt_dir, 2'b11);
            @(posedge clk); #1;
            chk($sformatf("v%0d_loaded", i), cnt_int, v.start_v);
            chk($sformatf("v%0d_load_off", i), cnt_load, 0);
            for (int k = 0; k < v.steps; k++) begin
                chk($sformatf("v%0d_dir%0d", i, k), cnt_dir, v.dir);
                @(posedge clk); #1;
            end
            chk($sformatf("v%0d_hold", i), cnt_dir, 2'b11);
            chk($sformatf("v%0d_busy_end", i), busy, 1);
            chk($sformatf("v%0d_early_done", i), done, 0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done", i), done, 1);
            chk($sformatf("v%0d_busy_off", i), busy, 0);
            chk($sformatf("v%0d_final", i), cnt_int, v.final_v);
            @(posedge clk); #1;
            chk($sformatf("v%0d_done_off", i), done, 0);
        end
        $display("vector %0d: start=%b end=%b mode=%0d applied", i, v.sv, v.ev, v.md);
    endtask

    // Counter readout and direction per cycle for bounce -1 <-> +1 after load.
    // An endpoint is visible in its equal cycle, the TURN hold and the cycle that steps away.
    int         bseq[10] = '{-1, 0, 1, 1, 1, 0, -1, -1, -1, 0};
    logic [1:0] bdir[10] = '{2'b10, 2'b10, 2'b11, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10};

    initial begin
        vecs[0] = '{8'hFF, 8'hFB, 1'b0, 1'b0, 0, 3, 2'b10, 3};
        // +5 = 11100101, -2 = 11110110
        vecs[1] = '{8'hE5, 8'hF6, 1'b0, 1'b0, 5, 7, 2'b01, -2};
        // +11 = 11101001, -3 = 11110111
        vecs[2] = '{8'hE9, 8'hF7, 1'b0, 1'b0, 11, 14, 2'b01, -3};
        vecs[3] = '{8'hAA, 8'hAA, 1'b0, 1'b0, 40, 0, 2'b11, 40};
        vecs[4] = '{8'h55, 8'hAA, 1'b0, 1'b0, -40, 80, 2'b10, 40};
        vecs[5] = '{8'hFF, 8'hF3, 1'b0, 1'b1, 0, 0, 2'b11, 0};
        vecs[6] = '{8'h3F, 8'hFF, 1'b0, 1'b1, 0, 0, 2'b11, 0};
        vecs[7] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 0, 0, 2'b11, 0};

        #2;
        chk("rst_busy", busy, 0);
        chk("rst_load", cnt_load, 0);
        chk("rst_data", cnt_data, 8'hFF);
        chk("rst_dir", cnt_dir, 2'b11);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 8; i++) apply_vec(i);

        // Bounce -1 <-> +1, then stop part-way through a step.
        kick(8'hFD, 8'hFE, 1'b1);
        chk("b_load", cnt_load, 1);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("b_cnt%0d", k), cnt_int, bseq[k]);
            chk($sformatf("b_dir%0d", k), cnt_dir, bdir[k]);
            chk($sformatf("b_busy%0d", k), busy, 1);
            chk($sformatf("b_done%0d", k), done, 0);
        end
        @(negedge clk); stop = 1'b1; #1;
        chk("b_stop_dir", cnt_dir, 2'b11);
        chk("b_stop_load", cnt_load, 0);
        @(posedge clk); #1;
        stop = 1'b0;
        chk("b_stop_busy", busy, 0);
        chk("b_stop_done", done, 0);
        chk("b_stop_cnt", cnt_int, 0);
        @(posedge clk); #1;
        chk("b_stop_done2", done, 0);
        $display("bounce -1<->+1 with stop applied");

        // Illegal code on the counter feedback mid-run.
        kick(8'h55, 8'hAA, 1'b0);
        @(posedge clk); #1;
        chk("ill_dir_pre", cnt_dir, 2'b10);
        @(negedge clk); force_ill = 1'b1; #1;
        chk("ill_dir", cnt_dir, 2'b11);
        chk("ill_err_early", err, 0);
        @(posedge clk); #1;
        force_ill = 1'b0;
        chk("ill_err", err, 1);
        chk("ill_busy", busy, 0);
        @(posedge clk); #1;
        chk("ill_err_clr", err, 0);
        chk("ill_load", cnt_load, 0);
        $display("illegal feedback code applied");

        // Start held high through DONE must not relaunch from DONE.
        kick(8'hAA, 8'hAA, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("dn_done", done, 1);
        @(posedge clk); #1;
        chk("dn_busy", busy, 0);
        chk("dn_load", cnt_load, 0);
        start = 1'b0;
        @(posedge clk); #1;
        $display("start during DONE applied");

        // Asynchronous reset between edges mid-run.
        kick(8'h55, 8'hAA, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        chk("ar_busy_pre", busy, 1);
        rst_n = 1'b0; #1;
        chk("ar_busy", busy, 0);
        chk("ar_dir", cnt_dir, 2'b11);
        chk("ar_load", cnt_load, 0);
        chk("ar_data", cnt_data, 8'hFF);
        chk("ar_done", done, 0);
        chk("ar_err", err, 0);
        @(negedge clk); rst_n = 1'b1;
        $display("async reset mid-run applied");
        apply_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
